// File: rtl/pci_arb_pkg.sv
// Shared state type, default sizing and wrap helper for the PCI bus arbiter.
// Build option: PCI_ARB_PARK_EN enables bus parking on the last owner.
package pci_arb_pkg;

   localparam int DEF_N_MASTERS   = 4;
   localparam int DEF_GNT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2,
      ST_TURN  = 2'd3
   } arb_state_e;

   // With parking the rest state is PARK; it takes over the IDLE encoding.
   localparam arb_state_e ST_PARK = ST_IDLE;

   function automatic int unsigned rr_wrap(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
// Build option PCI_ARB_PARK_EN has no effect on this block.
module pci_rr_picker
   import pci_arb_pkg::*;
#(
   parameter int N = DEF_N_MASTERS
)(
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] winner,
   output logic                 valid
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] idx;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path infers a latch.
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = IW'(rr_wrap(32'(ptr), unsigned'(i), unsigned'(N)));
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin grants, held through a transaction, revoked when unused.
// Build option: PCI_ARB_PARK_EN parks the bus on the last owner when nobody requests.
module pci_arbiter
   import pci_arb_pkg::*;
#(
   parameter int N_MASTERS   = DEF_N_MASTERS,
   parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_MASTERS-1:0]         req_n,
   input  logic                         frame,
   input  logic                         irdy,
   output logic [N_MASTERS-1:0]         gnt_n,
   output logic [$clog2(N_MASTERS)-1:0] owner,
   output logic                         bus_idle
);

   localparam int            IW       = $clog2(N_MASTERS);
   localparam int            CW       = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(GNT_TIMEOUT - 1);

`ifdef PCI_ARB_PARK_EN
   localparam logic [N_MASTERS-1:0] GNT_RST = ~N_MASTERS'(1);
`else
   localparam logic [N_MASTERS-1:0] GNT_RST = '1;
`endif

   arb_state_e           state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
   logic                 bus_idle_q, bus_idle_d;

   logic [N_MASTERS-1:0] req;
   logic [N_MASTERS-1:0] owner_vec;
   logic                 owner_req, other_req;
   logic                 frame_lo, irdy_lo, idle_now;
   logic [IW-1:0]        pick_idx;
   logic                 pick_vld;
   logic [IW-1:0]        owner_nxt;

   assign req       = ~req_n;
   assign owner_vec = N_MASTERS'(1) << owner_q;
   assign owner_req = req[owner_q];
   assign other_req = |(req & ~owner_vec);
   assign owner_nxt = IW'(rr_wrap(32'(owner_q), 32'd1, unsigned'(N_MASTERS)));

   // An undriven or unknown FRAME#/IRDY# misses the == 1'b0 test and so reads as idle.
   always_comb begin
      frame_lo = 1'b0;
      irdy_lo  = 1'b0;
      if (frame == 1'b0) frame_lo = 1'b1;
      if (irdy == 1'b0)  irdy_lo  = 1'b1;
   end

   assign idle_now = !frame_lo && !irdy_lo;

   pci_rr_picker #(
      .N (N_MASTERS)
   ) u_picker (
      .req    (req),
      .ptr    (ptr_q),
      .winner (pick_idx),
      .valid  (pick_vld)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      gnt_n_d    = gnt_n_q;
      bus_idle_d = idle_now;

      case (state_q)
`ifdef PCI_ARB_PARK_EN
         ST_PARK: begin
            if (frame_lo) begin
               state_d = ST_BUSY;
               ptr_d   = owner_nxt;
            end else if (other_req) begin
               state_d = ST_TURN;
               gnt_n_d = '1;
            end else if (owner_req) begin
               state_d = ST_GRANT;
               cnt_d   = '0;
            end
         end
`else
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_GRANT;
               owner_d = pick_idx;
               gnt_n_d = ~(N_MASTERS'(1) << pick_idx);
               cnt_d   = '0;
            end
         end
`endif

         // Frame falling outranks both withdrawal and timeout on the same edge.
         ST_GRANT: begin
            if (frame_lo) begin
               state_d = ST_BUSY;
               ptr_d   = owner_nxt;
            end else if (!owner_req) begin
               state_d = ST_TURN;
               gnt_n_d = '1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_TURN;
               gnt_n_d = '1;
               ptr_d   = owner_nxt;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_BUSY: begin
            if (idle_now) begin
               if (other_req) begin
                  state_d = ST_TURN;
                  gnt_n_d = '1;
               end else if (owner_req) begin
                  state_d = ST_GRANT;
                  cnt_d   = '0;
               end else begin
`ifdef PCI_ARB_PARK_EN
                  state_d = ST_PARK;
`else
                  state_d = ST_IDLE;
                  gnt_n_d = '1;
`endif
               end
            end
         end

         ST_TURN: begin
            if (pick_vld) begin
               state_d = ST_GRANT;
               owner_d = pick_idx;
               gnt_n_d = ~(N_MASTERS'(1) << pick_idx);
               cnt_d   = '0;
            end else begin
`ifdef PCI_ARB_PARK_EN
               state_d = ST_PARK;
               gnt_n_d = ~owner_vec;
`else
               state_d = ST_IDLE;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_n_d = GNT_RST;
         end
      endcase
   end

   // NOTE: non-blocking assignments so each flop sees the others' pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         gnt_n_q    <= GNT_RST;
         bus_idle_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         gnt_n_q    <= gnt_n_d;
         bus_idle_q <= bus_idle_d;
      end
   end

   assign gnt_n    = gnt_n_q;
   assign owner    = owner_q;
   assign bus_idle = bus_idle_q;

endmodule
